approx_divider: RTL and testbench

//  Iterative radix-2 restoring unsigned divider: the subtractive counterpart of the approximate adder.

---
 rtl/approx_pkg.sv | 16 +
 rtl/approx_sub_step.sv | 40 ++++
 rtl/approx_divider.sv | 202 ++++++++++++++++++++
 tb/tb_approx_divider.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/approx_pkg.sv
// approx_pkg: shared types and helpers for the approximate arithmetic units.
//   approx_div_state_t : divider FSM states
//   APPROX_LV_MAX      : largest supported count of approximated low bits
//   cnt_width()        : width of an iteration counter that holds w-1
package approx_pkg;

   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} approx_div_state_t;

   localparam int unsigned APPROX_LV_MAX = 63;

   // Counter width able to hold values 0..w-1
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/approx_sub_step.sv
// approx_sub_step: combinational WIDTH+1-bit trial subtract a - b.
//   Bits below APPROX_LV are OR-approximated (a | ~b) and produce no borrow;
//   bits at and above APPROX_LV are an exact add of ~b with carry-in 1.
// Ports:
//   a      in  WIDTH+1  minuend (shifted partial remainder)
//   b      in  WIDTH    subtrahend (divisor)
//   diff   out WIDTH+1  trial difference
//   borrow out 1        1 when the exact upper part went negative
module approx_sub_step #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned APPROX_LV = 0
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   diff,
   output logic             borrow
);

   localparam int unsigned HW = WIDTH + 1 - APPROX_LV;
   localparam int unsigned SW = HW + 1;

   logic [WIDTH:0] nb;
   logic [HW:0]    sum;

   assign nb  = ~{1'b0, b};

   // Exact upper part: a + ~b + 1, carry-out 0 means borrow
   assign sum = {1'b0, a[WIDTH:APPROX_LV]} + {1'b0, nb[WIDTH:APPROX_LV]} + SW'(1);

   assign diff[WIDTH:APPROX_LV] = sum[HW-1:0];
   assign borrow                = ~sum[HW];

   // Approximated low part
   generate
      if (APPROX_LV > 0) begin : g_lo
         assign diff[APPROX_LV-1:0] = a[APPROX_LV-1:0] | nb[APPROX_LV-1:0];
      end
   endgenerate

endmodule

// File: rtl/approx_divider.sv
// approx_divider: iterative radix-2 restoring unsigned divider whose trial
// subtract is approximated below bit APPROX_LV. One quotient bit per cycle,
// valid/ready request and response handshakes.
// Ports:
//   clk, reset (async, active-high)
//   req_valid/req_ready, dividend, divisor       request side
//   resp_valid/resp_ready, quotient, remainder,
//   div_by_zero                                  response side
//   quot_err (only with APPROX_DIV_ERR_EN)       exact ^ approximate quotient
// Optional feature macro: APPROX_DIV_ERR_EN adds a shadow exact datapath and quot_err.
module approx_divider
   import approx_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned APPROX_LV = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
`ifdef APPROX_DIV_ERR_EN
   ,
   output logic [WIDTH-1:0] quot_err
`endif
);

   localparam int unsigned CW = cnt_width(WIDTH);

   approx_div_state_t state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  dq_q, dq_d;      // dividend shifts out the top, quotient shifts in the bottom
   logic [WIDTH-1:0]  dvs_q, dvs_d;
   logic [WIDTH-1:0]  rem_q, rem_d;
   logic              req_ready_d, resp_valid_d, dbz_d;
   logic [WIDTH-1:0]  quotient_d, remainder_d;

   // One iteration of the main datapath
   logic [WIDTH:0]    r_shift, diff, rem_sel;
   logic              borrow;
   logic [WIDTH-1:0]  rem_step, dq_step;
   logic              unused_rem_msb;

   assign r_shift = {rem_q, dq_q[WIDTH-1]};

   approx_sub_step #(.WIDTH(WIDTH), .APPROX_LV(APPROX_LV)) u_step (
      .a      (r_shift),
      .b      (dvs_q),
      .diff   (diff),
      .borrow (borrow)
   );

   assign rem_sel        = borrow ? r_shift : diff;
   assign rem_step       = rem_sel[WIDTH-1:0];
   assign unused_rem_msb = rem_sel[WIDTH];
   assign dq_step        = {dq_q[WIDTH-2:0], ~borrow};

`ifdef APPROX_DIV_ERR_EN
   // Shadow exact datapath running in lockstep
   logic [WIDTH-1:0] rx_q, rx_d, qx_q, qx_d, quot_err_d;
   logic [WIDTH:0]   rx_shift, diff_x, rx_sel;
   logic             borrow_x;
   logic [WIDTH-1:0] rx_step, qx_step;
   logic             unused_rx_msb;

   assign rx_shift = {rx_q, dq_q[WIDTH-1]};

   approx_sub_step #(.WIDTH(WIDTH), .APPROX_LV(0)) u_step_exact (
      .a      (rx_shift),
      .b      (dvs_q),
      .diff   (diff_x),
      .borrow (borrow_x)
   );

   assign rx_sel        = borrow_x ? rx_shift : diff_x;
   assign rx_step       = rx_sel[WIDTH-1:0];
   assign unused_rx_msb = rx_sel[WIDTH];
   assign qx_step       = {qx_q[WIDTH-2:0], ~borrow_x};
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      dq_d         = dq_q;
      dvs_d        = dvs_q;
      rem_d        = rem_q;
      req_ready_d  = req_ready;
      resp_valid_d = resp_valid;
      quotient_d   = quotient;
      remainder_d  = remainder;
      dbz_d        = div_by_zero;
`ifdef APPROX_DIV_ERR_EN
      rx_d         = rx_q;
      qx_d         = qx_q;
      quot_err_d   = quot_err;
`endif
      unique case (state_q)
         DIV_IDLE: begin
            if (req_valid && req_ready) begin
               dq_d        = dividend;
               dvs_d       = divisor;
               rem_d       = '0;
               cnt_d       = CW'(WIDTH - 1);
               req_ready_d = 1'b0;
`ifdef APPROX_DIV_ERR_EN
               rx_d        = '0;
               qx_d        = '0;
`endif
               if (divisor == '0) begin
                  state_d      = DIV_DONE;
                  resp_valid_d = 1'b1;
                  quotient_d   = '1;
                  remainder_d  = dividend;
                  dbz_d        = 1'b1;
`ifdef APPROX_DIV_ERR_EN
                  quot_err_d   = '0;
`endif
               end else begin
                  state_d = DIV_BUSY;
               end
            end
         end
         DIV_BUSY: begin
            dq_d  = dq_step;
            rem_d = rem_step;
`ifdef APPROX_DIV_ERR_EN
            rx_d  = rx_step;
            qx_d  = qx_step;
`endif
            if (cnt_q == '0) begin
               state_d      = DIV_DONE;
               resp_valid_d = 1'b1;
               quotient_d   = dq_step;
               remainder_d  = rem_step;
               dbz_d        = 1'b0;
`ifdef APPROX_DIV_ERR_EN
               quot_err_d   = qx_step ^ dq_step;
`endif
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DIV_DONE: begin
            if (resp_ready) begin
               state_d      = DIV_IDLE;
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d      = DIV_IDLE;
            resp_valid_d = 1'b0;
            req_ready_d  = 1'b1;
         end
      endcase
   end

   // State, datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= DIV_IDLE;
         cnt_q       <= '0;
         dq_q        <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef APPROX_DIV_ERR_EN
         rx_q        <= '0;
         qx_q        <= '0;
         quot_err    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dq_q        <= dq_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         req_ready   <= req_ready_d;
         resp_valid  <= resp_valid_d;
         quotient    <= quotient_d;
         remainder   <= remainder_d;
         div_by_zero <= dbz_d;
`ifdef APPROX_DIV_ERR_EN
         rx_q        <= rx_d;
         qx_q        <= qx_d;
         quot_err    <= quot_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_approx_divider.sv
// tb_approx_divider: drives an exact (APPROX_LV=0) and an approximate
// (APPROX_LV=4) divider in lockstep and checks both against a reference model.
module tb_approx_divider;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          resp_ready = 1'b0;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;

   logic          req_ready0, resp_valid0, dbz0;
   logic [W-1:0]  q0, r0;
   logic          req_ready4, resp_valid4, dbz4;
   logic [W-1:0]  q4, r4;
`ifdef APPROX_DIV_ERR_EN
   logic [W-1:0]  qe0, qe4;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   approx_divider #(.WIDTH(W), .APPROX_LV(0)) u_dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready0),
      .dividend(dividend), .divisor(divisor), .resp_valid(resp_valid0),
      .resp_ready(resp_ready), .quotient(q0), .remainder(r0), .div_by_zero(dbz0)
`ifdef APPROX_DIV_ERR_EN
      , .quot_err(qe0)
`endif
   );

   approx_divider #(.WIDTH(W), .APPROX_LV(4)) u_dut4 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready4),
      .dividend(dividend), .divisor(divisor), .resp_valid(resp_valid4),
      .resp_ready(resp_ready), .quotient(q4), .remainder(r4), .div_by_zero(dbz4)
`ifdef APPROX_DIV_ERR_EN
      , .quot_err(qe4)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Long-division reference: the upper part of each trial subtract is an
   // exact integer difference, the low lv bits are R'|~divisor.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input int lv, output logic [W-1:0] q,
                                   output logic [W-1:0] r);
      logic [63:0] rr, rp, hr, hd, t, m;
      logic        brw;
      rr = '0;
      q  = '0;
      m  = (64'd1 << lv) - 64'd1;
      for (int i = W - 1; i >= 0; i--) begin
         rp  = (rr << 1) | {63'd0, a[i]};
         hr  = rp >> lv;
         hd  = {32'd0, b} >> lv;
         brw = hr < hd;
         t   = ((hr - hd) << lv) | ((rp | ~{32'd0, b}) & m);
         rr  = (brw ? rp : t) & 64'h0000_0000_FFFF_FFFF;
         q   = {q[W-2:0], ~brw};
      end
      r = rr[W-1:0];
   endfunction

   // One full transaction; hold = cycles resp_ready stays low after resp_valid,
   // poke = present a competing request while the response is pending.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input bit poke);
      int           lat;
      logic [W-1:0] eq, er, aq, ar;
      lat = 0;
      while (!req_ready0 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("req_ready_idle", req_ready0, 1);
      dividend  = a;
      divisor   = b;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("req_ready_after_accept", req_ready0, 0);
      lat = 1;
      while (!resp_valid0 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 64'(lat), (b == '0) ? 64'd1 : 64'(W + 1));
      check("lockstep_valid", resp_valid4, 1);

      if (b == '0) begin
         eq = '1; er = a; aq = '1; ar = a;
      end else begin
         eq = a / b; er = a % b;
         ref_div(a, b, 4, aq, ar);
      end
      check("q_exact", q0, eq);
      check("r_exact", r0, er);
      check("dbz_exact", dbz0, (b == '0));
      check("q_lv4", q4, aq);
      check("r_lv4", r4, ar);
      check("dbz_lv4", dbz4, (b == '0));
`ifdef APPROX_DIV_ERR_EN
      check("qerr_exact", qe0, 0);
      check("qerr_lv4", qe4, (b == '0) ? '0 : (eq ^ aq));
`endif

      if (poke) begin
         dividend  = ~a;
         divisor   = 32'd3;
         req_valid = 1'b1;
      end
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check("hold_valid", resp_valid0, 1);
         check("hold_req_ready", req_ready0, 0);
         check("hold_q", q0, eq);
         check("hold_r", r0, er);
         check("hold_q_lv4", q4, aq);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      check("resp_valid_drop", resp_valid0, 0);
      check("req_ready_back", req_ready0, 1);
      check("q_kept_after_resp", q0, eq);
   endtask

   initial begin
      logic [W-1:0] a, b;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready0, 1);
      check("rst_resp_valid", resp_valid0, 0);
      check("rst_q", q0, 0);
      check("rst_r", r0, 0);
      check("rst_dbz", dbz0, 0);
`ifdef APPROX_DIV_ERR_EN
      check("rst_qerr", qe4, 0);
`endif
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      run_op(32'd100, 32'd7, 0, 1'b0);
      check("dir_100_7_q", q0, 14);
      check("dir_100_7_r", r0, 2);
      run_op(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
      run_op(32'h5, 32'h9, 0, 1'b0);
      run_op(32'h1234, 32'd0, 0, 1'b0);
      check("dir_dbz_q", q0, 32'hFFFF_FFFF);
      check("dir_dbz_r", r0, 32'h1234);

      // Backpressure with a competing request pending
      run_op(32'd1000, 32'd33, 10, 1'b1);
      run_op(32'd77, 32'd5, 0, 1'b0);

      // Reset in the middle of an operation
      dividend  = 32'd100;
      divisor   = 32'd7;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("abort_req_ready", req_ready0, 1);
      check("abort_resp_valid", resp_valid0, 0);
      check("abort_q_cleared", q0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_resp", resp_valid0, 0);
      run_op(32'd100, 32'd7, 0, 1'b0);
      check("after_abort_q", q0, 14);
      check("after_abort_r", r0, 2);

      // Randomized operands
      for (int n = 0; n < 1500; n++) begin
         a = $urandom;
         if ($urandom_range(0, 9) == 0) a = a >> $urandom_range(0, 31);
         b = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 49) == 0) b = '0;
         run_op(a, b, $urandom_range(0, 2), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
